// File: rtl/tensor_reg_arbiter.sv
// Burst sequencer/arbiter sharing the single-port 32 x DW tensor register file among NREQ units.
// Define TREG_ARB_FIXED_PRIO_EN for fixed (lowest index wins) priority; default is round-robin.
module tensor_reg_arbiter #(
   parameter int NREQ = 3,
   parameter int DW   = 256,
   parameter int AW   = 5,
   parameter int IDW  = 2
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     reqWe,
   input  logic [NREQ*AW-1:0]  reqAddr,
   input  logic [NREQ*AW-1:0]  reqLen,
   input  logic [NREQ*DW-1:0]  reqWdata,
   output logic [NREQ-1:0]     gnt,
   output logic                gntLast,
   output logic                rValid,
   output logic [IDW-1:0]      rId,
   output logic                rLast,
   output logic [DW-1:0]       rData,
   output logic                tregEna,
   output logic                tregRd,
   output logic [AW-1:0]       tregAddr,
   output logic [DW-1:0]       tregWdata,
   input  logic [DW-1:0]       tregRdata
);

   typedef enum logic {
      ARB   = 1'b0,
      BURST = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [IDW-1:0] id_q, id_d;
   logic [AW-1:0]  base_q, base_d;
   logic [AW-1:0]  len_q, len_d;
   logic           we_q, we_d;
   logic [AW-1:0]  beat_q, beat_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic           rvalid_q, rvalid_d;
   logic [IDW-1:0] rid_q, rid_d;
   logic           rlast_q, rlast_d;

   logic           win_found;
   logic [IDW-1:0] win_id;
   logic           last_beat;
   logic [IDW-1:0] next_ptr;

   assign last_beat = (beat_q == len_q);

`ifdef TREG_ARB_FIXED_PRIO_EN
   assign next_ptr = '0;

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_found = 1'b1;
            win_id    = IDW'(i);
         end
      end
   end
`else
   function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] start, input int offset);
      int idx;
      idx = int'(start) + offset;
      if (idx >= NREQ) idx = idx - NREQ;
      return IDW'(idx);
   endfunction

   assign next_ptr = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

   // Scan from the farthest candidate back to ptr_q so the first requester at/after ptr_q wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[rr_index(ptr_q, k)]) begin
            win_found = 1'b1;
            win_id    = rr_index(ptr_q, k);
         end
      end
   end
`endif

   // NOTE: every flop uses non-blocking assignment so all of them update from pre-edge values.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q  <= ARB;
         id_q     <= '0;
         base_q   <= '0;
         len_q    <= '0;
         we_q     <= 1'b0;
         beat_q   <= '0;
         ptr_q    <= '0;
         rvalid_q <= 1'b0;
         rid_q    <= '0;
         rlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         base_q   <= base_d;
         len_q    <= len_d;
         we_q     <= we_d;
         beat_q   <= beat_d;
         ptr_q    <= ptr_d;
         rvalid_q <= rvalid_d;
         rid_q    <= rid_d;
         rlast_q  <= rlast_d;
      end
   end

   // NOTE: each signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      base_d  = base_q;
      len_d   = len_q;
      we_d    = we_q;
      beat_d  = beat_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         ARB: begin
            if (win_found) begin
               state_d = BURST;
               id_d    = win_id;
               base_d  = reqAddr[win_id*AW +: AW];
               len_d   = reqLen[win_id*AW +: AW];
               we_d    = reqWe[win_id];
               beat_d  = '0;
            end
         end
         BURST: begin
            if (last_beat) begin
               state_d = ARB;
               ptr_d   = next_ptr;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         default: state_d = ARB;
      endcase

      rvalid_d = (state_q == BURST) && !we_q;
      rid_d    = rvalid_d ? id_q : rid_q;
      rlast_d  = rvalid_d && last_beat;
   end

   always_comb begin
      gnt       = '0;
      gntLast   = 1'b0;
      tregEna   = 1'b0;
      tregRd    = 1'b0;
      tregAddr  = '0;
      tregWdata = '0;
      if (state_q == BURST) begin
         gnt[id_q] = 1'b1;
         gntLast   = last_beat;
         tregEna   = 1'b1;
         tregRd    = ~we_q;
         tregAddr  = base_q + beat_q;
         tregWdata = reqWdata[id_q*DW +: DW];
      end
   end

   assign rValid = rvalid_q;
   assign rId    = rid_q;
   assign rLast  = rlast_q;
   assign rData  = tregRdata;

endmodule

// File: tb/tb_tensor_reg_arbiter.sv
// Self-checking bench for tensor_reg_arbiter: directed scenarios plus a randomized run checked
// every cycle against a transaction-level schedule model.
`timescale 1ns/1ps
module tb_tensor_reg_arbiter;
   localparam int NREQ = 3;
   localparam int DW   = 256;
   localparam int AW   = 5;
   localparam int IDW  = 2;

   logic                iClk = 1'b0;
   logic                iRst = 1'b1;
   logic [NREQ-1:0]     req = '0;
   logic [NREQ-1:0]     reqWe = '0;
   logic [NREQ*AW-1:0]  reqAddr = '0;
   logic [NREQ*AW-1:0]  reqLen = '0;
   logic [NREQ*DW-1:0]  reqWdata = '0;
   logic [NREQ-1:0]     gnt;
   logic                gntLast;
   logic                rValid;
   logic [IDW-1:0]      rId;
   logic                rLast;
   logic [DW-1:0]       rData;
   logic                tregEna;
   logic                tregRd;
   logic [AW-1:0]       tregAddr;
   logic [DW-1:0]       tregWdata;
   logic [DW-1:0]       tregRdata;

   logic [DW-1:0] env_mem [32];
   logic [DW-1:0] model_mem [32];
   int  n_checks = 0;
   int  n_errors = 0;
   bit  chk_en = 1'b0;

   always #5 iClk = ~iClk;

   tensor_reg_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .IDW(IDW)) dut (
      .iClk(iClk), .iRst(iRst), .req(req), .reqWe(reqWe), .reqAddr(reqAddr),
      .reqLen(reqLen), .reqWdata(reqWdata), .gnt(gnt), .gntLast(gntLast),
      .rValid(rValid), .rId(rId), .rLast(rLast), .rData(rData), .tregEna(tregEna),
      .tregRd(tregRd), .tregAddr(tregAddr), .tregWdata(tregWdata), .tregRdata(tregRdata)
   );

   // Register file behind the port
   always @(posedge iClk) begin
      if (tregEna) begin
         if (tregRd) tregRdata <= env_mem[tregAddr];
         else        env_mem[tregAddr] <= tregWdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   typedef struct {
      int id;
      bit we;
      int addr;
      bit last;
   } beat_t;

   beat_t          sched[$];
   int             ptr_m = 0;
   bit             ret_v = 1'b0;
   int             ret_id = 0;
   bit             ret_last = 1'b0;
   logic [DW-1:0]  ret_data = '0;

   task automatic model_arbitrate();
      int win;
      int idx;
      int len;
      int base;
      bit we;
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
         idx = (ptr_m + k) % NREQ;
         if (win < 0 && req[idx]) win = idx;
      end
      len  = int'(reqLen[win*AW +: AW]);
      base = int'(reqAddr[win*AW +: AW]);
      we   = reqWe[win];
      for (int k = 0; k <= len; k++)
         sched.push_back('{id: win, we: we, addr: (base + k) % 32, last: (k == len)});
`ifdef TREG_ARB_FIXED_PRIO_EN
      ptr_m = 0;
`else
      ptr_m = (win + 1) % NREQ;
`endif
   endtask

   task automatic model_step();
      beat_t         b;
      bit            nv;
      int            nid;
      bit            nlast;
      logic [DW-1:0] ndata;
      logic [DW-1:0] wd;
      nv = 1'b0; nid = 0; nlast = 1'b0; ndata = '0;
      check("m_rValid", 32'(rValid), 32'(ret_v));
      if (ret_v) begin
         check("m_rId", 32'(rId), 32'(ret_id));
         check("m_rLast", 32'(rLast), 32'(ret_last));
         check_data("m_rData", rData, ret_data);
      end
      if (sched.size() == 0) begin
         check("m_gnt_idle", 32'(gnt), 32'd0);
         check("m_gntLast_idle", 32'(gntLast), 32'd0);
         check("m_ena_idle", 32'(tregEna), 32'd0);
         if (!iRst && req != '0) model_arbitrate();
      end else begin
         b  = sched.pop_front();
         wd = reqWdata[b.id*DW +: DW];
         check("m_gnt", 32'(gnt), 32'd1 << b.id);
         check("m_gntLast", 32'(gntLast), 32'(b.last));
         check("m_ena", 32'(tregEna), 32'd1);
         check("m_rd", 32'(tregRd), 32'(!b.we));
         check("m_addr", 32'(tregAddr), 32'(b.addr));
         check_data("m_wdata", tregWdata, wd);
         if (b.we) begin
            model_mem[b.addr] = wd;
         end else begin
            nv = 1'b1; nid = b.id; nlast = b.last; ndata = model_mem[b.addr];
         end
      end
      ret_v = nv; ret_id = nid; ret_last = nlast; ret_data = ndata;
      if (iRst) begin
         sched.delete();
         ptr_m = 0;
         ret_v = 1'b0;
      end
   endtask

   initial begin
      forever begin
         @(negedge iClk);
         if (chk_en) model_step();
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive_cycle();
      @(posedge iClk);
      #1;
   endtask

   task automatic set_req(input int i, input bit we, input int addr, input int len);
      req[i]               = 1'b1;
      reqWe[i]             = we;
      reqAddr[i*AW +: AW]  = AW'(addr);
      reqLen[i*AW +: AW]   = AW'(len);
   endtask

   function automatic logic [DW-1:0] wpat(input int k);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(k);
      return {8{w}};
   endfunction

   initial begin
      int            wr_addr [4];
      int            order [4];
      logic [DW-1:0] wnew;
      logic [NREQ-1:0] done;

      wr_addr = '{30, 31, 0, 1};
`ifdef TREG_ARB_FIXED_PRIO_EN
      order = '{0, 0, 0, 0};
`else
      order = '{0, 1, 2, 0};
`endif
      wnew = {8{32'h5EED_F00D}};
      for (int a = 0; a < 32; a++) begin
         env_mem[a]   = {8{32'h1000_0000 + 32'(a)}};
         model_mem[a] = env_mem[a];
      end
      env_mem[7]   = {32{8'hA5}};
      model_mem[7] = {32{8'hA5}};

      // Reset and reset values
      @(posedge iClk);
      #1 chk_en = 1'b1;
      drive_cycle();
      @(negedge iClk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_gntLast", 32'(gntLast), 32'd0);
      check("rst_rValid", 32'(rValid), 32'd0);
      check("rst_rId", 32'(rId), 32'd0);
      check("rst_rLast", 32'(rLast), 32'd0);
      check("rst_ena", 32'(tregEna), 32'd0);
      check("rst_rd", 32'(tregRd), 32'd0);
      check("rst_addr", 32'(tregAddr), 32'd0);
      check_data("rst_wdata", tregWdata, '0);
      drive_cycle();
      iRst = 1'b0;

      // Single read of address 7
      drive_cycle();
      set_req(0, 1'b0, 7, 0);
      drive_cycle();
      @(negedge iClk);
      check("rd1_gnt", 32'(gnt), 32'd1);
      check("rd1_gntLast", 32'(gntLast), 32'd1);
      check("rd1_addr", 32'(tregAddr), 32'd7);
      check("rd1_rd", 32'(tregRd), 32'd1);
      drive_cycle();
      req = '0;
      @(negedge iClk);
      check("rd1_rValid", 32'(rValid), 32'd1);
      check("rd1_rId", 32'(rId), 32'd0);
      check("rd1_rLast", 32'(rLast), 32'd1);
      check_data("rd1_rData", rData, {32{8'hA5}});

      // Wrapping write burst, then read it back
      drive_cycle();
      set_req(1, 1'b1, 30, 3);
      for (int k = 0; k < 4; k++) begin
         drive_cycle();
         reqWdata[DW +: DW] = wpat(k);
         @(negedge iClk);
         check("wr_gnt", 32'(gnt), 32'd2);
         check("wr_addr", 32'(tregAddr), 32'(wr_addr[k]));
         check("wr_gntLast", 32'(gntLast), 32'(k == 3));
      end
      drive_cycle();
      set_req(1, 1'b0, 30, 3);
      for (int k = 0; k < 5; k++) begin
         drive_cycle();
         if (k == 4) req = '0;
         @(negedge iClk);
         if (k >= 1) begin
            check("rb_rValid", 32'(rValid), 32'd1);
            check_data("rb_rData", rData, wpat(k - 1));
            check("rb_rLast", 32'(rLast), 32'(k == 4));
         end
      end

      // Grant order with all three requesting from pointer 0
      drive_cycle();
      iRst = 1'b1;
      drive_cycle();
      iRst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, i, 0);
      @(negedge iClk);
      check("rr_arb_gnt", 32'(gnt), 32'd0);
      for (int c = 0; c < 7; c++) begin
         drive_cycle();
         @(negedge iClk);
         if (c % 2 == 0) check("rr_gnt", 32'(gnt), 32'd1 << order[c / 2]);
         else            check("rr_bubble", 32'(gnt), 32'd0);
      end
      drive_cycle();
      req = '0;

      // Rotation: requester 2 bursts, then 0 and 2 compete
      drive_cycle();
      iRst = 1'b1;
      drive_cycle();
      iRst = 1'b0;
      set_req(2, 1'b0, 3, 0);
      drive_cycle();
      @(negedge iClk);
      check("rot_gnt2", 32'(gnt), 32'd4);
      drive_cycle();
      set_req(0, 1'b0, 4, 0);
      drive_cycle();
      @(negedge iClk);
      check("rot_gnt0", 32'(gnt), 32'd1);
      drive_cycle();
      req = '0;

      // Reset on beat 3 of a read burst, then write/read ordering to address 5
      drive_cycle();
      set_req(0, 1'b0, 10, 7);
      for (int k = 0; k < 4; k++) begin
         drive_cycle();
         if (k == 3) iRst = 1'b1;
         @(negedge iClk);
         check("mid_gnt", 32'(gnt), 32'd1);
      end
      drive_cycle();
      iRst = 1'b0;
      set_req(0, 1'b1, 5, 0);
      set_req(1, 1'b0, 5, 0);
      reqWdata[0 +: DW] = wnew;
      @(negedge iClk);
      check("mid_ena", 32'(tregEna), 32'd0);
      check("mid_gnt_off", 32'(gnt), 32'd0);
      check("mid_rValid", 32'(rValid), 32'd0);
      drive_cycle();
      @(negedge iClk);
      check("wr5_gnt", 32'(gnt), 32'd1);
      check("wr5_rd", 32'(tregRd), 32'd0);
      check("wr5_addr", 32'(tregAddr), 32'd5);
      check_data("wr5_wdata", tregWdata, wnew);
      drive_cycle();
      req[0] = 1'b0;
      @(negedge iClk);
      check("wr5_bubble", 32'(gnt), 32'd0);
      drive_cycle();
      @(negedge iClk);
      check("rd5_gnt", 32'(gnt), 32'd2);
      check("rd5_addr", 32'(tregAddr), 32'd5);
      drive_cycle();
      req[1] = 1'b0;
      @(negedge iClk);
      check("rd5_rValid", 32'(rValid), 32'd1);
      check("rd5_rId", 32'(rId), 32'd1);
      check_data("rd5_rData", rData, wnew);

      // Randomized traffic with occasional reset
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge iClk);
         done = gnt & {NREQ{gntLast}};
         drive_cycle();
         iRst = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (done[i] || !req[i]) begin
               req[i] = 1'b0;
               if ($urandom_range(0, 3) == 0 || (done[i] && $urandom_range(0, 1) == 1))
                  set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                          ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                                      : int'($urandom_range(0, 5)));
            end
         end
         for (int w = 0; w < NREQ * DW / 32; w++) reqWdata[w*32 +: 32] = $urandom;
      end

      drive_cycle();
      iRst = 1'b0;
      req  = '0;
      repeat (40) drive_cycle();
      @(negedge iClk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tensor_reg_arbiter.md
# tensor_reg_arbiter

Sequencer and arbiter for the single-port 32 x 256-bit tensor register file. It shares the one register-file port between NREQ requesters, such as the load unit, MAC array and store unit. It grants whole bursts of consecutive-address accesses, drives the register-file port one beat per cycle, and returns read data tagged with the requester ID. It sits between the TPU datapath units and the tensor register file.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..4)
- DW, 256, tensor word width
- AW, 5, register address width (32 entries)
- IDW, 2, requester ID width

Ports:
- iClk  input  1  clock; all logic on posedge
- iRst  input  1  reset; synchronous, active-high
- req  input  NREQ  per-requester burst request, level
- reqWe  input  NREQ  1 = write burst, 0 = read burst
- reqAddr  input  NREQ*AW  burst base address, slice i = requester i
- reqLen  input  NREQ*AW  beats minus 1 (0..31)
- reqWdata  input  NREQ*DW  write data for the current beat
- gnt  output  NREQ  one-hot; high in each cycle the requester's beat is on the port
- gntLast  output  1  high with gnt on the final beat of a burst
- rValid  output  1  read data valid
- rId  output  IDW  requester owning rData
- rLast  output  1  final read beat of a burst
- rData  output  DW  read data, passed through from tregRdata
- tregEna  output  1  register-file enable
- tregRd  output  1  1 = read access, 0 = write access
- tregAddr  output  AW  register-file address
- tregWdata  output  DW  register-file write data
- tregRdata  input  DW  register-file read data, valid the cycle after a read beat

## Operation
- States: ARB, BURST.
- ARB:
  - Port idle: tregEna=0, gnt=0.
  - If any req is high, pick a winner with the priority scheme (see Configuration).
  - Latch winner ID, reqAddr, reqLen and reqWe; set beat counter = 0; go to BURST.
  - If no req is high, stay in ARB.
- BURST:
  - Drive tregEna=1, tregRd=~we, tregAddr=base+beat (mod 32, wraps 31 -> 0), tregWdata=reqWdata[id] (combinational mux), gnt[id]=1.
  - When beat==len: assert gntLast, rotate the priority pointer, go to ARB.
  - Otherwise increment beat.
- Requester obligations:
  - Hold req, reqWe, reqAddr and reqLen stable from request until gntLast.
  - Present new wdata in the cycle after each gnt.
  - Set up the next request in the ARB cycle following gntLast.
- Dropping req mid-burst is ignored; the burst completes. Write beats reuse whatever wdata is presented.
- Read return:
  - A read beat in cycle T sets rValid=1, rId=id and rLast=(beat was last) in cycle T+1.
  - rData=tregRdata in that cycle. rData is don't-care when rValid=0.
- Accesses are strictly serialized. A write burst followed by a read burst to the same address returns the new data.

## Timing
- Reset values: state ARB, pointer 0, gnt=0, gntLast=0, rValid=0, rId=0, rLast=0, tregEna=0, tregRd=0, tregAddr=0, tregWdata=0.
- Request sampled at end of ARB cycle N; beat k is on the port in cycle N+1+k.
- Read beat k: rValid in cycle N+2+k.
- A burst of L beats occupies L+1 port cycles, so there is one arbitration bubble between bursts.
- Reset asserted mid-burst: no further beats issue from the next cycle. A pending rValid is cleared. Register-file contents already written remain.
- Simultaneous requests are resolved only in ARB. Requests arriving during BURST wait.

## Configuration
- TREG_ARB_FIXED_PRIO_EN defined: fixed priority; lowest-index requesting unit always wins. The pointer is unused and stays 0.
- Not defined (default): round-robin. After a burst by requester i, the pointer becomes (i+1) mod NREQ. Search starts at the pointer and wraps.

## Test plan
- Single read: req0 only, addr 7, len 0, mem[7]=A5..A5 → gnt[0] plus gntLast one cycle later, tregAddr=7, tregRd=1; next cycle rValid=1, rId=0, rLast=1, rData=A5..A5.
- Wrapping write burst: req1 we=1, addr 30, len 3 → tregAddr 30,31,0,1 on four consecutive cycles, gntLast on the 4th. Read-back burst returns the written words in order.
- Round-robin: req0, req1 and req2 held high, len 0 → grant order 0,1,2,0 with one ARB bubble between beats. With TREG_ARB_FIXED_PRIO_EN the order is 0,0,0…
- Priority rotation: requester 2 bursts, then req0 and req2 are both high → requester 0 wins next.
- Reset mid-burst: read burst len 7, iRst asserted on beat 3 → from the next cycle tregEna=0, gnt=0, rValid=0, state ARB, pointer 0.
- Write-then-read ordering: req0 write addr 5 len 0 and req1 read addr 5 asserted together → write first, then the read returns the newly written data.
